// File: rtl/dmem_mmio_bridge.sv
// Data-side bridge for the RVI32 core: decodes word accesses to the data RAM,
// a small MMIO block (GPIO, 64-bit prescaled timer with compare interrupt) or unmapped space.
module dmem_mmio_bridge #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] MMIO_BASE = 32'h0000_1000,
    parameter int          GPIO_W    = 8,
    parameter int          PRESCALE  = 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [31:0]       daddr,
    input  logic [31:0]       ddata_w,
    input  logic              d_rw,
    output logic [31:0]       ddata_r,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    input  logic [31:0]       ram_rdata,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    localparam logic [5:0] OFF_GPIO     = 6'd0;
    localparam logic [5:0] OFF_MTIME_LO = 6'd1;
    localparam logic [5:0] OFF_MTIME_HI = 6'd2;
    localparam logic [5:0] OFF_MTIMECMP = 6'd3;
    localparam logic [5:0] OFF_CTRL     = 6'd4;

    logic [GPIO_W-1:0] gpio_reg;
    logic [63:0]       mtime_reg;
    logic [PW-1:0]     pre_cnt_reg;
    logic [PW-1:0]     pre_cnt_next;
    logic [31:0]       mtimecmp_reg;
    logic              en_reg;
    logic              pend_reg;
    logic              pend_next;

    logic              sel_ram;
    logic              sel_mmio;
    logic [5:0]        offset;
    logic              wr_mmio;
    logic              wr_gpio;
    logic              wr_cmp;
    logic              wr_ctrl;
    logic              tick;
    logic              match;
    logic [31:0]       mtime_lo_inc;
    logic [31:0]       gpio_rd;
    logic              unused_addr_lsbs;

    // RAM decode wins when both regions overlap, so sel_mmio is masked by sel_ram.
    assign sel_ram  = (daddr[31:RAM_AW+2] == '0);
    assign sel_mmio = (daddr[31:8] == MMIO_BASE[31:8]) & ~sel_ram;
    assign offset   = daddr[7:2];
    assign unused_addr_lsbs = ^daddr[1:0];

    assign ram_addr  = daddr[RAM_AW+1:2];
    assign ram_wdata = ddata_w;
    assign ram_we    = d_rw & sel_ram & RESET_N;

    assign wr_mmio = d_rw & sel_mmio;
    assign wr_gpio = wr_mmio & (offset == OFF_GPIO);
    assign wr_cmp  = wr_mmio & (offset == OFF_MTIMECMP);
    assign wr_ctrl = wr_mmio & (offset == OFF_CTRL);

    assign tick         = (pre_cnt_reg == PRE_LAST);
    assign pre_cnt_next = tick ? '0 : pre_cnt_reg + PW'(1);
    assign mtime_lo_inc = mtime_reg[31:0] + 32'd1;

    // Compare against the value mtime_lo is about to take, using pre-write EN/MTIMECMP.
    assign match = en_reg & tick & (mtime_lo_inc == mtimecmp_reg);

    always_comb begin
        pend_next = pend_reg;
        if (match) begin
            pend_next = 1'b1;
        end else if (wr_ctrl & ddata_w[1]) begin
            pend_next = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_gpio_rd
            if (gi < GPIO_W) begin : g_bit
                assign gpio_rd[gi] = gpio_reg[gi];
            end else begin : g_zero
                assign gpio_rd[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        ddata_r = 32'd0;
        if (sel_ram) begin
            ddata_r = ram_rdata;
        end else if (sel_mmio) begin
            case (offset)
                OFF_GPIO:     ddata_r = gpio_rd;
                OFF_MTIME_LO: ddata_r = mtime_reg[31:0];
                OFF_MTIME_HI: ddata_r = mtime_reg[63:32];
                OFF_MTIMECMP: ddata_r = mtimecmp_reg;
                OFF_CTRL:     ddata_r = {30'd0, pend_reg, en_reg};
                default:      ddata_r = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            gpio_reg     <= '0;
            mtime_reg    <= 64'd0;
            pre_cnt_reg  <= '0;
            mtimecmp_reg <= 32'hFFFF_FFFF;
            en_reg       <= 1'b0;
            pend_reg     <= 1'b0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
            if (tick) begin
                mtime_reg <= mtime_reg + 64'd1;
            end
            if (wr_gpio) begin
                gpio_reg <= ddata_w[GPIO_W-1:0];
            end
            if (wr_cmp) begin
                mtimecmp_reg <= ddata_w;
            end
            if (wr_ctrl) begin
                en_reg <= ddata_w[0];
            end
            pend_reg <= pend_next;
        end
    end

    assign gpio_out  = gpio_reg;
    assign timer_irq = pend_reg;

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
// Bench for dmem_mmio_bridge: directed accesses push expected values into a queue,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_dmem_mmio_bridge;

    localparam logic [31:0] MB   = 32'h0000_1000;
    localparam logic [31:0] IDLE = 32'h8000_0000;

    localparam int S_RDATA = 0;
    localparam int S_GPIO  = 1;
    localparam int S_IRQ   = 2;
    localparam int S_WE    = 3;
    localparam int S_RADDR = 4;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] daddr;
    logic [31:0] ddata_w;
    logic        d_rw;
    logic [31:0] ddata_r;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    typedef struct {
        string       nm;
        logic [31:0] val;
        int          sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    logic [31:0] mon_act;
    int   errors = 0;
    int   checks = 0;
    int   n = 0;

    logic [31:0] ram_mem [0:1023];

    dmem_mmio_bridge #(
        .RAM_AW(10), .MMIO_BASE(MB), .GPIO_W(8), .PRESCALE(4)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w), .d_rw(d_rw),
        .ddata_r(ddata_r), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Asynchronous-read RAM model with a clocked write port.
    always @(posedge CLK) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end
    assign ram_rdata = ram_mem[ram_addr];

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RDATA: return ddata_r;
            S_GPIO:  return 32'(gpio_out);
            S_IRQ:   return 32'(timer_irq);
            S_WE:    return 32'(ram_we);
            default: return 32'(ram_addr);
        endcase
    endfunction

    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_act = pick(mon_e.sel);
            checks++;
            if (mon_act !== mon_e.val) begin
                errors++;
                $display("FAIL %s @step%0d: actual=%h required=%h", mon_e.nm, n, mon_act, mon_e.val);
            end else begin
                $display("ok   %s @step%0d: %h", mon_e.nm, n, mon_act);
            end
        end
    end

    task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
        exp_q.push_back('{nm, v, sel});
    endtask

    task automatic step(input logic [31:0] a, input logic rw, input logic [31:0] wd);
        @(posedge CLK);
        #1;
        daddr   = a;
        d_rw    = rw;
        ddata_w = wd;
        n++;
    endtask

    task automatic at_step(input int k, input logic [31:0] a, input logic rw, input logic [31:0] wd);
        while (n < k - 1) step(IDLE, 1'b0, 32'd0);
        step(a, rw, wd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 1'b0;
        daddr   = IDLE;
        d_rw    = 1'b0;
        ddata_w = 32'd0;

        // In reset: RAM write suppressed, registers at reset values, reads still decode.
        step(32'h10, 1'b1, 32'h1111_1111);
        expect_v("rst_ram_we", S_WE, 32'd0);
        expect_v("rst_gpio", S_GPIO, 32'd0);
        expect_v("rst_irq", S_IRQ, 32'd0);
        step(MB + 32'h0C, 1'b0, 32'd0);
        expect_v("rst_cmp_rd", S_RDATA, 32'hFFFF_FFFF);
        step(IDLE, 1'b0, 32'd0);
        RESET_N = 1'b1;
        n = 0;

        // Prescaler of 4: mtime becomes 1 on the fourth edge after reset release.
        at_step(3, MB + 32'h04, 1'b0, 32'd0);   expect_v("mtime_lo_3", S_RDATA, 32'd0);
        at_step(4, MB + 32'h04, 1'b0, 32'd0);   expect_v("mtime_lo_4", S_RDATA, 32'd1);
        at_step(5, MB + 32'h08, 1'b0, 32'd0);   expect_v("mtime_hi_5", S_RDATA, 32'd0);

        at_step(6, 32'h10, 1'b1, 32'hDEAD_BEEF);
        expect_v("ram_we_wr", S_WE, 32'd1);
        expect_v("ram_addr_wr", S_RADDR, 32'd4);
        at_step(7, 32'h10, 1'b0, 32'd0);
        expect_v("ram_rd_10", S_RDATA, 32'hDEAD_BEEF);
        expect_v("ram_we_rd", S_WE, 32'd0);
        at_step(8, 32'hFFC, 1'b1, 32'h1234_5678);
        expect_v("ram_we_top", S_WE, 32'd1);
        expect_v("ram_addr_top", S_RADDR, 32'h3FF);
        at_step(9, 32'hFFC, 1'b0, 32'd0);       expect_v("ram_rd_top", S_RDATA, 32'h1234_5678);

        // GPIO write: the read in the write cycle still shows the old value.
        at_step(10, MB, 1'b1, 32'h1A5);
        expect_v("gpio_wr_we", S_WE, 32'd0);
        expect_v("gpio_before", S_GPIO, 32'd0);
        expect_v("gpio_rd_old", S_RDATA, 32'd0);
        at_step(11, MB, 1'b0, 32'd0);
        expect_v("gpio_rd", S_RDATA, 32'h0000_00A5);
        expect_v("gpio_out", S_GPIO, 32'hA5);
        at_step(12, MB + 32'h40, 1'b1, 32'hFFFF_FFFF);
        at_step(13, MB + 32'h40, 1'b0, 32'd0);
        expect_v("mmio_unlisted_rd", S_RDATA, 32'd0);
        expect_v("gpio_hold", S_GPIO, 32'hA5);
        at_step(14, IDLE, 1'b1, 32'h5A);
        expect_v("unmapped_we", S_WE, 32'd0);
        expect_v("unmapped_rd", S_RDATA, 32'd0);
        at_step(15, MB + 32'h0C, 1'b0, 32'd0);  expect_v("cmp_untouched", S_RDATA, 32'hFFFF_FFFF);
        at_step(16, MB + 32'h04, 1'b1, 32'h777);
        at_step(17, MB + 32'h04, 1'b0, 32'd0);  expect_v("mtime_lo_ro", S_RDATA, 32'd4);
        at_step(18, MB + 32'h10, 1'b0, 32'd0);  expect_v("ctrl_reset", S_RDATA, 32'd0);
        at_step(19, 32'h10, 1'b0, 32'd0);       expect_v("ram_keep", S_RDATA, 32'hDEAD_BEEF);

        at_step(100, MB + 32'h04, 1'b0, 32'd0); expect_v("mtime_lo_100", S_RDATA, 32'd25);

        // Preload mtime_lo to all ones between ticks; the tick at edge 104 carries into HI.
        at_step(101, IDLE, 1'b0, 32'd0);
        force dut.mtime_reg = 64'h0000_0000_FFFF_FFFF;
        #2;
        release dut.mtime_reg;
        at_step(102, MB + 32'h04, 1'b0, 32'd0); expect_v("pre_lo", S_RDATA, 32'hFFFF_FFFF);
        at_step(103, MB + 32'h08, 1'b0, 32'd0); expect_v("pre_hi", S_RDATA, 32'd0);
        at_step(104, MB + 32'h08, 1'b0, 32'd0); expect_v("carry_hi", S_RDATA, 32'd1);
        at_step(105, MB + 32'h04, 1'b0, 32'd0); expect_v("carry_lo", S_RDATA, 32'd0);

        // mtime_lo at step k (k>=104) is k/4-26. EN=0: a compare hit must not set PEND.
        at_step(106, MB + 32'h0C, 1'b1, 32'd2);
        at_step(112, IDLE, 1'b0, 32'd0);        expect_v("en0_irq_112", S_IRQ, 32'd0);
        at_step(113, IDLE, 1'b0, 32'd0);        expect_v("en0_irq_113", S_IRQ, 32'd0);
        at_step(114, MB + 32'h10, 1'b0, 32'd0); expect_v("en0_ctrl", S_RDATA, 32'd0);

        at_step(115, MB + 32'h0C, 1'b1, 32'd10);
        at_step(116, MB + 32'h10, 1'b1, 32'd1);
        at_step(117, MB + 32'h10, 1'b0, 32'd0); expect_v("ctrl_en", S_RDATA, 32'd1);
        at_step(118, MB + 32'h0C, 1'b0, 32'd0); expect_v("cmp_rd", S_RDATA, 32'd10);
        at_step(143, IDLE, 1'b0, 32'd0);        expect_v("irq_before", S_IRQ, 32'd0);
        at_step(144, MB + 32'h10, 1'b0, 32'd0);
        expect_v("irq_rise", S_IRQ, 32'd1);
        expect_v("ctrl_pend", S_RDATA, 32'd3);

        // W1C coinciding with a match at edge 148: set wins.
        at_step(145, MB + 32'h0C, 1'b1, 32'd11);
        at_step(147, MB + 32'h10, 1'b1, 32'd3);
        at_step(148, MB + 32'h10, 1'b0, 32'd0);
        expect_v("w1c_vs_match_irq", S_IRQ, 32'd1);
        expect_v("w1c_vs_match_ctrl", S_RDATA, 32'd3);
        at_step(149, MB + 32'h10, 1'b1, 32'd3);
        at_step(150, MB + 32'h10, 1'b0, 32'd0);
        expect_v("w1c_irq", S_IRQ, 32'd0);
        expect_v("w1c_ctrl", S_RDATA, 32'd1);

        // Build gpio=FF and PEND=1, then reset.
        at_step(151, MB, 1'b1, 32'hFF);
        at_step(152, MB + 32'h0C, 1'b1, 32'd13);
        at_step(155, IDLE, 1'b0, 32'd0);        expect_v("irq_pre_13", S_IRQ, 32'd0);
        at_step(156, IDLE, 1'b0, 32'd0);
        expect_v("irq_13", S_IRQ, 32'd1);
        expect_v("gpio_ff", S_GPIO, 32'hFF);
        at_step(157, 32'h10, 1'b1, 32'hCAFE_F00D);
        RESET_N = 1'b0;
        expect_v("rst2_ram_we", S_WE, 32'd0);
        expect_v("rst2_irq_held", S_IRQ, 32'd1);
        at_step(158, MB + 32'h0C, 1'b0, 32'd0);
        expect_v("rst2_cmp", S_RDATA, 32'hFFFF_FFFF);
        expect_v("rst2_irq", S_IRQ, 32'd0);
        expect_v("rst2_gpio", S_GPIO, 32'd0);
        at_step(159, MB + 32'h04, 1'b0, 32'd0);
        RESET_N = 1'b1;
        expect_v("rst2_lo", S_RDATA, 32'd0);
        at_step(160, MB + 32'h08, 1'b0, 32'd0); expect_v("rst2_hi", S_RDATA, 32'd0);
        at_step(161, 32'h10, 1'b0, 32'd0);      expect_v("rst2_ram_kept", S_RDATA, 32'hDEAD_BEEF);

        @(posedge CLK);
        @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
